// File: rtl/tristate_bus_pkg.sv
// rtl/tristate_bus_pkg.sv - shared types and constants for the tristate bus port
package tristate_bus_pkg;

    // Width of the turnaround down-counter; holds TURN-1 for TURN up to 15.
    localparam int TURN_W = 4;

    // Default bus and data word width.
    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_LISTEN   = 2'd0,
        ST_TURN_ON  = 2'd1,
        ST_DRIVE    = 2'd2,
        ST_TURN_OFF = 2'd3
    } state_e;

endpackage : tristate_bus_pkg

// File: rtl/tristate_bus_turn_ctr.sv
// rtl/tristate_bus_turn_ctr.sv - loadable turnaround down-counter with zero flag
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset, count returns to 0
//   load_i     load load_val_i (wins over dec_i)
//   load_val_i value to load
//   dec_i      decrement by one, holds at 0
//   zero_o     count is 0
module tristate_bus_turn_ctr #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule : tristate_bus_turn_ctr

// File: rtl/tristate_bus_port.sv
// rtl/tristate_bus_port.sv - half-duplex endpoint for a shared tristated data bus
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   grant         bus ownership from the arbiter
//   tx_valid/tx_data/tx_ready  local words to send while granted
//   rx_valid/rx_data           words captured from the peer while listening
//   bus_data      shared tristate bus, driven only in DRIVE
//   bus_stb_out   our strobe, high for each cycle a new word is on the bus
//   bus_stb_in    peer strobe
//   bus_oe        high exactly when this port drives bus_data
//   err/err_clr   sticky strobe-while-not-listening error and its clear
module tristate_bus_port
    import tristate_bus_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned TURN  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             grant,
    input  logic             tx_valid,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_ready,
    output logic             rx_valid,
    output logic [WIDTH-1:0] rx_data,
    inout  wire  [WIDTH-1:0] bus_data,
    output logic             bus_stb_out,
    input  logic             bus_stb_in,
    output logic             bus_oe,
    output logic             err,
    input  logic             err_clr
);

    localparam logic [TURN_W-1:0] TURN_LOAD = TURN_W'(TURN - 1);

    state_e state_q;
    state_e state_d;

    logic ctr_load;
    logic ctr_dec;
    logic ctr_zero;

    logic [WIDTH-1:0] drv_q;
    logic [WIDTH-1:0] drv_d;
    logic             stb_q;
    logic             stb_d;
    logic [WIDTH-1:0] rx_data_q;
    logic [WIDTH-1:0] rx_data_d;
    logic             rx_valid_q;
    logic             rx_valid_d;
    logic             err_q;
    logic             err_d;

    logic accept;
    logic capture;
    logic violation;

    tristate_bus_turn_ctr #(
        .W (TURN_W)
    ) u_turn_ctr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (ctr_load),
        .load_val_i (TURN_LOAD),
        .dec_i      (ctr_dec),
        .zero_o     (ctr_zero)
    );

    // Next-state logic. The counter is loaded on entry to either turnaround
    // state and counts down while there; leaving happens on the zero cycle,
    // so each turnaround lasts exactly TURN cycles.
    always_comb begin
        state_d  = state_q;
        ctr_load = 1'b0;
        ctr_dec  = 1'b0;
        tx_ready = 1'b0;
        unique case (state_q)
            ST_LISTEN: begin
                if (grant) begin
                    state_d  = ST_TURN_ON;
                    ctr_load = 1'b1;
                end
            end
            ST_TURN_ON: begin
                if (!grant) begin
                    state_d  = ST_TURN_OFF;
                    ctr_load = 1'b1;
                end else if (ctr_zero) begin
                    state_d = ST_DRIVE;
                end else begin
                    ctr_dec = 1'b1;
                end
            end
            ST_DRIVE: begin
                tx_ready = grant;
                // A word accepted on the last granted edge is already on the
                // bus this cycle (stb_q), so leaving at this edge still lets
                // the in-flight drive cycle complete.
                if (!grant) begin
                    state_d  = ST_TURN_OFF;
                    ctr_load = 1'b1;
                end
            end
            ST_TURN_OFF: begin
                // Re-grant is ignored until the bus has been released via LISTEN.
                if (ctr_zero) begin
                    state_d = ST_LISTEN;
                end else begin
                    ctr_dec = 1'b1;
                end
            end
            default: begin
                state_d = ST_LISTEN;
            end
        endcase
    end

    assign accept    = tx_valid && tx_ready;
    assign capture   = (state_q == ST_LISTEN) && bus_stb_in;
    assign violation = (state_q != ST_LISTEN) && bus_stb_in;

    always_comb begin
        drv_d      = accept ? tx_data : drv_q;
        stb_d      = accept;
        rx_valid_d = capture;
        rx_data_d  = capture ? bus_data : rx_data_q;
        // Set has priority over clear so a violation is never lost.
        err_d      = violation ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_LISTEN;
            drv_q      <= '0;
            stb_q      <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            drv_q      <= drv_d;
            stb_q      <= stb_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            err_q      <= err_d;
        end
    end

    // Output enable decodes straight from the state register, so an
    // asynchronous reset releases the bus without waiting for a clock.
    assign bus_oe      = (state_q == ST_DRIVE);
    assign bus_data    = bus_oe ? drv_q : {WIDTH{1'bz}};
    assign bus_stb_out = stb_q;
    assign rx_valid    = rx_valid_q;
    assign rx_data     = rx_data_q;
    assign err         = err_q;

endmodule : tristate_bus_port

// File: doc/tristate_bus_port.md
Name: tristate_bus_port

Overview:
- Half-duplex endpoint for a shared, tristated W-bit data bus. It drives the bus only while it holds the grant, and releases the bus to high-Z otherwise.
- Released: listens for the peer's strobe and captures words. Granted: accepts words over a valid/ready interface and drives each one for exactly one cycle with its own strobe.
- Enforces turnaround (high-Z) cycles on every direction change so two endpoints never drive together.
- Sits between a local producer/consumer and the board-level tristate bus. One instance sits at each end.

Parameters:
- WIDTH, 8, bus and data word width in bits.
- TURN, 1, number of high-Z turnaround cycles on each direction change (legal range 1..15).

Ports:
- clk  input  1  single clock, all logic rising-edge.
- rst  input  1  asynchronous, active-high reset.
- grant  input  1  bus ownership from the arbiter; 1 means this port may drive after turnaround.
- tx_valid  input  1  local word available.
- tx_data  input  WIDTH  local word.
- tx_ready  output  1  port accepts tx_data this cycle.
- rx_valid  output  1  one-cycle pulse, captured word on rx_data.
- rx_data  output  WIDTH  last captured word, held until the next capture.
- bus_data  inout  WIDTH  shared bus; driven only in DRIVE, otherwise all bits z.
- bus_stb_out  output  1  our strobe; 1 for each cycle a valid word is on bus_data.
- bus_stb_in  input  1  peer strobe.
- bus_oe  output  1  1 exactly when bus_data is driven (observability).
- err  output  1  sticky collision/protocol error.
- err_clr  input  1  synchronous clear of err.

Behaviour:
- Reset (async, any time, including mid-drive):
  - state = LISTEN, turnaround counter = 0.
  - bus_data = z on the same edge reset asserts, with no clock required.
  - bus_oe, bus_stb_out, tx_ready, rx_valid, err = 0; rx_data = 0.
- States: LISTEN, TURN_ON, DRIVE, TURN_OFF. Encoding lives in the package.
- LISTEN:
  - bus high-Z, tx_ready = 0.
  - If bus_stb_in = 1 at an edge: rx_data <= bus_data and rx_valid = 1 for the following cycle. Back-to-back strobes give back-to-back pulses.
  - If grant = 1: go to TURN_ON and load the counter with TURN-1.
  - A capture in the same cycle grant rises still completes.
- TURN_ON:
  - bus high-Z, tx_ready = 0; decrement the counter.
  - At counter = 0, go to DRIVE.
  - If grant drops here, go directly to TURN_OFF (counter = TURN-1).
- DRIVE:
  - tx_ready = grant.
  - On tx_valid & tx_ready: the registered word appears on bus_data, with bus_stb_out = 1 and bus_oe = 1, in the next cycle only.
  - Idle cycles in DRIVE: bus_oe = 1, bus_stb_out = 0, bus_data holds the last driven word (all 0 before the first word).
  - Grant low: tx_ready = 0. After any in-flight drive cycle completes, go to TURN_OFF with counter = TURN-1.
- TURN_OFF:
  - bus high-Z, tx_ready = 0; decrement the counter.
  - At counter = 0, go to LISTEN. This happens even if grant is already high again; re-entry goes through LISTEN to TURN_ON.
- Latency:
  - grant rise (sampled) to first tx_ready = TURN+1 cycles.
  - Accepted word to strobe on bus = 1 cycle.
  - Peer strobe to rx_valid = 1 cycle.
- err:
  - Set when bus_stb_in = 1 in any state other than LISTEN.
  - Set/clear priority: set wins over err_clr in the same cycle.
  - Strobes outside LISTEN are ignored for capture.
- tx_valid with tx_ready = 0: no acceptance. The producer holds the word.

Decomposition:
- Package tristate_bus_pkg: state enum, TURN_W = 4 counter width constant, default WIDTH.
- Sub-module tristate_bus_turn_ctr: loadable down-counter with zero flag, used for both turnaround states. All else inline.

Test Plan:
- Reset release, grant = 0, peer idle → bus_data === 8'bz, bus_oe = 0, all outputs 0. Assert rst mid-DRIVE → bus_data === z immediately, before the next clock edge.
- Listen: peer drives 8'hA5 with bus_stb_in = 1 for one cycle → rx_valid pulses 1 cycle later, rx_data = 8'hA5 and held. Then 8'h3C, 8'hC3 on consecutive cycles → two consecutive pulses.
- Grant with TURN = 2: grant rises at cycle 0 → bus z through cycle 2, tx_ready = 1 at cycle 3. Send 8'h5A → bus_data = 8'h5A with bus_stb_out = 1 for exactly one cycle.
- Grant drop while tx_valid is held high → in-flight word still driven. Then 2 cycles of z (TURN = 2), then LISTEN. No further tx_ready.
- Peer strobe during DRIVE → err = 1 and sticky, no rx_valid. err_clr pulse → err = 0. err_clr in the same cycle as a new violation → err stays 1.
- Grant re-asserted during TURN_OFF → completes TURN_OFF, then passes through LISTEN and TURN_ON. bus_oe never high within TURN cycles of the previous release.
